// File: rtl/pc_gen.sv
// Fetch-stage PC register with prioritised next-PC selection and a single-entry
// buffer that holds a redirect raised during a stall until the stall clears.
module pc_gen #(
    parameter int               WIDTH    = 32,
    parameter int               N_SRC    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_in,
    input  logic [N_SRC-1:0]       redir_valid_in,
    input  logic [N_SRC*WIDTH-1:0] redir_addr_in,
    input  logic                   exc_in,
    input  logic                   eret_in,
    input  logic [WIDTH-1:0]       epc_in,
    output logic [WIDTH-1:0]       pc_out,
    output logic [WIDTH-1:0]       pc_plus4_out,
    output logic                   adel_out,
    output logic                   pend_out
);

    logic             anyRedir;
    logic [WIDTH-1:0] winAddr;
    logic [WIDTH-1:0] pendAddr;

    // Scan from the top down so the lowest-index valid channel is the last writer.
    always_comb begin
        anyRedir = |redir_valid_in;
        winAddr  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (redir_valid_in[i]) begin
                winAddr = redir_addr_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign pc_plus4_out = pc_out + WIDTH'(4);
    assign adel_out     = |pc_out[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out   <= RESET_PC;
            pend_out <= 1'b0;
            pendAddr <= '0;
        end else if (exc_in) begin
            pc_out   <= EXC_VEC;
            pend_out <= 1'b0;
        end else if (eret_in) begin
            pc_out   <= epc_in;
            pend_out <= 1'b0;
        end else if (stall_in) begin
            // A newer stalled redirect replaces any older one still waiting.
            if (anyRedir) begin
                pendAddr <= winAddr;
                pend_out <= 1'b1;
            end
        end else if (pend_out) begin
            pc_out   <= pendAddr;
            pend_out <= 1'b0;
        end else if (anyRedir) begin
            pc_out <= winAddr;
        end else begin
            pc_out <= pc_plus4_out;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic, each edge compared
// against a queue-based reference model of the next-PC rules.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] chAddr [4];
    logic [127:0] redirAddr;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc, pcPlus4;
    logic        adel, pend;

    int checks = 0;
    int failures = 0;

    // Reference model state: committed PC and a queue holding at most one deferred target.
    logic [31:0] mPc;
    logic [31:0] pendQ[$];

    assign redirAddr = {chAddr[3], chAddr[2], chAddr[1], chAddr[0]};

    pc_gen dut (
        .clk(clk), .reset(reset), .stall_in(stall), .redir_valid_in(valid),
        .redir_addr_in(redirAddr), .exc_in(exc), .eret_in(eret), .epc_in(epc),
        .pc_out(pc), .pc_plus4_out(pcPlus4), .adel_out(adel), .pend_out(pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag);
        logic [31:0] expPend;
        expPend = (pendQ.size() != 0) ? 32'd1 : 32'd0;
        chk({tag, ".pc"}, pc, mPc);
        chk({tag, ".plus4"}, pcPlus4, mPc + 32'd4);
        chk({tag, ".adel"}, {31'd0, adel}, ((mPc % 4) != 0) ? 32'd1 : 32'd0);
        chk({tag, ".pend"}, {31'd0, pend}, expPend);
    endtask

    // Model next-PC from the rules, advance one edge, then compare.
    task automatic tick(input string tag);
        int w;
        logic [31:0] nPc;
        w = -1;
        foreach (chAddr[i]) if (valid[i] && w < 0) w = i;
        nPc = mPc;
        if (exc) begin
            nPc = EXC_PC; pendQ.delete();
        end else if (eret) begin
            nPc = epc; pendQ.delete();
        end else if (stall) begin
            if (w >= 0) begin pendQ.delete(); pendQ.push_back(chAddr[w]); end
        end else if (pendQ.size() != 0) begin
            nPc = pendQ.pop_front();
        end else if (w >= 0) begin
            nPc = chAddr[w];
        end else begin
            nPc = mPc + 32'd4;
        end
        @(posedge clk);
        #1;
        mPc = nPc;
        chkAll(tag);
    endtask

    task automatic idle();
        stall = 1'b0; valid = '0; exc = 1'b0; eret = 1'b0;
    endtask

    initial begin
        foreach (chAddr[i]) chAddr[i] = '0;
        mPc = RST_PC;
        pendQ.delete();

        // 1. reset then free-running fetch
        @(posedge clk); @(posedge clk); #1;
        chkAll("reset");
        reset = 1'b0;
        tick("seq1"); tick("seq2"); tick("seq3");
        tick("seq4");

        // 2. lowest index wins (pc now 3010)
        chk("pc3010", pc, 32'h0000_3010);
        chAddr[1] = 32'h3100; chAddr[2] = 32'h3200; valid = 4'b0110;
        tick("lowidx");
        chk("lowidx.abs", pc, 32'h0000_3100);

        // 3. stalled redirect, release with a competing ch0
        idle(); stall = 1'b1; chAddr[3] = 32'h3400; valid = 4'b1000;
        tick("stallReq");
        valid = '0;
        tick("stallHold1"); tick("stallHold2");
        stall = 1'b0; chAddr[0] = 32'h3500; valid = 4'b0001;
        tick("release");
        chk("release.abs", pc, 32'h0000_3400);
        idle();
        tick("afterRelease");

        // 4. exception beats stall/pending and eret
        stall = 1'b1; valid = 4'b1000;
        tick("stallAgain");
        valid = '0; exc = 1'b1; eret = 1'b1; epc = 32'h3020;
        tick("excEret");
        chk("exc.abs", pc, EXC_PC);

        // 5. eret to misaligned target, then wrap
        idle(); eret = 1'b1; epc = 32'h3022;
        tick("eretMis");
        chk("adel.abs", {31'd0, adel}, 32'd1);
        idle(); chAddr[0] = 32'hFFFF_FFFC; valid = 4'b0001;
        tick("toTop");
        idle();
        tick("wrap");
        chk("wrap.abs", pc, 32'h0);

        // 6. async reset while a redirect is pending
        stall = 1'b1; chAddr[2] = 32'h3700; valid = 4'b0100;
        tick("pendBeforeReset");
        idle();
        #2 reset = 1'b1;
        #1;
        mPc = RST_PC; pendQ.delete();
        chkAll("asyncReset");
        #1 reset = 1'b0;
        tick("resume");
        chk("resume.abs", pc, 32'h0000_3004);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 2) == 0);
            valid = 4'($urandom);
            if ($urandom_range(0, 1) == 0) valid = '0;
            foreach (chAddr[i]) chAddr[i] = $urandom;
            exc  = ($urandom_range(0, 19) == 0);
            eret = ($urandom_range(0, 14) == 0);
            epc  = $urandom;
            tick("rand");
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
